// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : router_pkg
// Description : Shared constants for the 1x3 router: byte width, FIFO depth,
//               header field positions and the stored header-flag bit.
// Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

   localparam int DATA_W       = 8;
   localparam int FIFO_DEPTH   = 16;

   localparam int ADDR_LSB     = 0;
   localparam int ADDR_MSB     = 1;
   localparam int LEN_LSB      = 2;
   localparam int LEN_MSB      = 7;

   // Each stored entry is {header_flag, byte}; the flag sits just above the byte.
   localparam int HDR_FLAG_BIT = DATA_W;

   localparam int PKT_CNT_W    = 7;

endpackage : router_pkg
`default_nettype wire

// File: rtl/router_fifo.sv
`default_nettype none
// ============================================================================
// Module      : router_fifo
// Description : Per-port output buffer of the 1x3 router with packet-boundary
//               tracking so the output idles at zero between packets.
// Revision    : 1.0 - initial release
// ============================================================================
module router_fifo
   import router_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH,
   parameter int WIDTH = DATA_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             soft_reset,
   input  logic             write_enb,
   input  logic             read_enb,
   input  logic             lfd_state,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH:0]           mem_q [DEPTH];
   logic [AW:0]              wr_ptr_q, wr_ptr_d;
   logic [AW:0]              rd_ptr_q, rd_ptr_d;
   logic [PKT_CNT_W-1:0]     pkt_cnt_q, pkt_cnt_d;
   logic [WIDTH-1:0]         data_out_q, data_out_d;
   logic [WIDTH:0]           rd_entry;
   logic                     wr_acc;
   logic                     rd_acc;
   logic                     mem_we;

   // Flags come only from registered pointers, so they move only at clock edges.
   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                     (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign data_out = data_out_q;

   assign wr_acc   = write_enb && !full;
   assign rd_acc   = read_enb && !empty;
   assign mem_we   = wr_acc && !soft_reset;
   assign rd_entry = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      pkt_cnt_d  = pkt_cnt_q;
      data_out_d = data_out_q;
      if (soft_reset) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         pkt_cnt_d  = '0;
         data_out_d = '0;
      end else begin
         if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
         end
         if (rd_acc) begin
            rd_ptr_d   = rd_ptr_q + (AW+1)'(1);
            data_out_d = rd_entry[WIDTH-1:0];
            // Header: remaining bytes are the payload length plus the parity byte.
            if (rd_entry[WIDTH]) begin
               pkt_cnt_d = {1'b0, rd_entry[LEN_MSB:LEN_LSB]} + PKT_CNT_W'(1);
            end else if (pkt_cnt_q != '0) begin
               pkt_cnt_d = pkt_cnt_q - PKT_CNT_W'(1);
            end
         end else if (pkt_cnt_q == '0) begin
            data_out_d = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         pkt_cnt_q  <= '0;
         data_out_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         pkt_cnt_q  <= pkt_cnt_d;
         data_out_q <= data_out_d;
      end
   end

   // Storage is deliberately left out of both resets.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[wr_ptr_q[AW-1:0]] <= {lfd_state, data_in};
      end
   end

endmodule : router_fifo
`default_nettype wire

// File: tb/tb_router_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_fifo
// Description : Self-checking bench for router_fifo against a queue-based
//               packet model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_fifo;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       soft_reset = 1'b0;
   logic       write_enb = 1'b0;
   logic       read_enb = 1'b0;
   logic       lfd_state = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic [7:0] data_out;
   logic       full;
   logic       empty;

   int n_vec = 0;
   int n_err = 0;

   logic [8:0] m_q [$];
   int         m_cnt = 0;
   logic [7:0] m_dout = 8'h00;

   router_fifo #(.DEPTH(16), .WIDTH(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .soft_reset (soft_reset),
      .write_enb  (write_enb),
      .read_enb   (read_enb),
      .lfd_state  (lfd_state),
      .data_in    (data_in),
      .data_out   (data_out),
      .full       (full),
      .empty      (empty)
   );

   always #5 clk = ~clk;

   function automatic logic m_full();
      return m_q.size() == 16;
   endfunction

   function automatic logic m_empty();
      return m_q.size() == 0;
   endfunction

   // One clock: drive at negedge, advance the model at posedge, settle 1 time unit.
   task automatic apply(input logic we, input logic re, input logic lfd,
                        input logic srst, input logic [7:0] din);
      logic       rd_ok;
      logic       wr_ok;
      logic [8:0] e;
      @(negedge clk);
      write_enb  = we;
      read_enb   = re;
      lfd_state  = lfd;
      soft_reset = srst;
      data_in    = din;
      @(posedge clk);
      if (srst) begin
         m_q.delete();
         m_cnt  = 0;
         m_dout = 8'h00;
      end else begin
         rd_ok = re && !m_empty();
         wr_ok = we && !m_full();
         if (rd_ok) begin
            e      = m_q.pop_front();
            m_dout = e[7:0];
            if (e[8]) m_cnt = int'(e[7:2]) + 1;
            else if (m_cnt > 0) m_cnt = m_cnt - 1;
         end else if (m_cnt == 0) begin
            m_dout = 8'h00;
         end
         if (wr_ok) m_q.push_back({lfd, din});
      end
      #1;
   endtask

   task automatic test_reset();
      #12;
      n_vec++;
      if (empty !== 1'b1 || full !== 1'b0 || data_out !== 8'h00) begin
         n_err++;
         $display("FAIL reset_state: empty=%b full=%b dout=%h, want empty=1 full=0 dout=00",
                  empty, full, data_out);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_packet();
      logic [7:0] pkt [4];
      pkt[0] = 8'h0A; pkt[1] = 8'h11; pkt[2] = 8'h22; pkt[3] = 8'h33;
      for (int i = 0; i < 4; i++) apply(1'b1, 1'b0, (i == 0), 1'b0, pkt[i]);
      for (int i = 0; i < 4; i++) begin
         apply(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
         n_vec++;
         if (data_out !== pkt[i] || data_out !== m_dout) begin
            n_err++;
            $display("FAIL packet_read%0d: dout=%h, want %h", i, data_out, pkt[i]);
         end
      end
      apply(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      n_vec++;
      if (data_out !== 8'h00 || empty !== 1'b1) begin
         n_err++;
         $display("FAIL packet_idle: dout=%h empty=%b, want 00 and 1", data_out, empty);
      end
   endtask

   task automatic test_full();
      for (int i = 0; i < 16; i++) apply(1'b1, 1'b0, 1'b0, 1'b0, 8'($urandom_range(0, 254)));
      n_vec++;
      if (full !== 1'b1 || empty !== 1'b0) begin
         n_err++;
         $display("FAIL full_after16: full=%b empty=%b, want 1 0", full, empty);
      end
      apply(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF);
      n_vec++;
      if (full !== 1'b1 || m_q.size() != 16) begin
         n_err++;
         $display("FAIL full_drop: full=%b, want 1", full);
      end
      for (int i = 0; i < 16; i++) begin
         apply(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
         n_vec++;
         if (data_out !== m_dout || data_out === 8'hFF) begin
            n_err++;
            $display("FAIL full_read%0d: dout=%h, want %h", i, data_out, m_dout);
         end
      end
      n_vec++;
      if (empty !== 1'b1 || full !== 1'b0) begin
         n_err++;
         $display("FAIL full_drained: empty=%b full=%b, want 1 0", empty, full);
      end
   endtask

   task automatic test_full_rw();
      for (int i = 0; i < 16; i++) apply(1'b1, 1'b0, 1'b0, 1'b0, 8'($urandom_range(0, 127)));
      apply(1'b1, 1'b1, 1'b0, 1'b0, 8'hAA);
      n_vec++;
      if (full !== 1'b0 || data_out !== m_dout) begin
         n_err++;
         $display("FAIL fullrw_flag: full=%b dout=%h, want 0 %h", full, data_out, m_dout);
      end
      for (int i = 0; i < 16; i++) begin
         apply(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
         n_vec++;
         if (data_out !== m_dout || data_out === 8'hAA) begin
            n_err++;
            $display("FAIL fullrw_read%0d: dout=%h, want %h", i, data_out, m_dout);
         end
      end
      n_vec++;
      if (empty !== 1'b1) begin
         n_err++;
         $display("FAIL fullrw_empty: empty=%b, want 1", empty);
      end
   endtask

   task automatic test_stall();
      logic [7:0] last;
      last = 8'($urandom_range(1, 255));
      apply(1'b1, 1'b0, 1'b1, 1'b0, 8'h14);
      apply(1'b1, 1'b0, 1'b0, 1'b0, 8'($urandom_range(1, 255)));
      apply(1'b1, 1'b0, 1'b0, 1'b0, last);
      for (int i = 0; i < 3; i++) apply(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 3; i++) begin
         apply(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
         n_vec++;
         if (data_out !== last || data_out !== m_dout) begin
            n_err++;
            $display("FAIL stall_hold%0d: dout=%h, want %h", i, data_out, last);
         end
      end
   endtask

   task automatic test_soft_reset();
      apply(1'b1, 1'b0, 1'b1, 1'b0, 8'h20);
      apply(1'b1, 1'b0, 1'b0, 1'b0, 8'h44);
      apply(1'b1, 1'b0, 1'b0, 1'b0, 8'h55);
      apply(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      apply(1'b1, 1'b0, 1'b0, 1'b1, 8'h5A);
      n_vec++;
      if (empty !== 1'b1 || data_out !== 8'h00 || full !== 1'b0) begin
         n_err++;
         $display("FAIL soft_reset: empty=%b dout=%h full=%b, want 1 00 0",
                  empty, data_out, full);
      end
      apply(1'b1, 1'b0, 1'b0, 1'b0, 8'h66);
      n_vec++;
      if (empty !== 1'b0) begin
         n_err++;
         $display("FAIL soft_recover: empty=%b, want 0", empty);
      end
      apply(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      n_vec++;
      if (data_out !== 8'h66 || empty !== 1'b1) begin
         n_err++;
         $display("FAIL soft_recover_read: dout=%h empty=%b, want 66 1", data_out, empty);
      end
   endtask

   task automatic test_random();
      logic we, re, lfd, srst;
      for (int i = 0; i < 400; i++) begin
         we   = ($urandom_range(0, 99) < 60);
         re   = ($urandom_range(0, 99) < 50);
         lfd  = ($urandom_range(0, 99) < 15);
         srst = ($urandom_range(0, 99) < 2);
         apply(we, re, lfd, srst, 8'($urandom));
         n_vec++;
         if (data_out !== m_dout || full !== m_full() || empty !== m_empty()) begin
            n_err++;
            $display("FAIL random%0d: dout=%h full=%b empty=%b, want %h %b %b",
                     i, data_out, full, empty, m_dout, m_full(), m_empty());
         end
      end
   endtask

   task automatic test_async_reset();
      apply(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
      for (int i = 0; i < 5; i++) apply(1'b1, 1'b0, (i == 0), 1'b0, 8'h1C + 8'(i));
      apply(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      write_enb = 1'b0;
      read_enb  = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      n_vec++;
      if (empty !== 1'b1 || full !== 1'b0 || data_out !== 8'h00) begin
         n_err++;
         $display("FAIL async_reset: empty=%b full=%b dout=%h, want 1 0 00",
                  empty, full, data_out);
      end
      m_q.delete();
      m_cnt  = 0;
      m_dout = 8'h00;
      @(negedge clk);
      reset = 1'b0;
      apply(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      n_vec++;
      if (empty !== 1'b1 || data_out !== 8'h00) begin
         n_err++;
         $display("FAIL async_after: empty=%b dout=%h, want 1 00", empty, data_out);
      end
   endtask

   initial begin
      test_reset();
      test_packet();
      test_full();
      test_full_rw();
      test_stall();
      test_soft_reset();
      test_random();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_router_fifo
`default_nettype wire
